// File: rtl/phy_wifi_pkg.sv
// Shared constants and types for the WiFi PHY receive path.
//   RX_BUF_DEPTH / RX_BUF_ADDR_W : default RX word buffer geometry
//   FRAME_LEN_W                  : width of the latched frame length
//   rx_state_e                   : receive-buffer frame state (IDLE / RECV)
//   sat_inc_len                  : saturating increment for frame word counts
package phy_wifi_pkg;

  localparam int RX_BUF_DEPTH  = 8;
  localparam int RX_BUF_ADDR_W = 3;
  localparam int FRAME_LEN_W   = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_e;

  // Frame lengths stick at the all-ones value instead of wrapping.
  function automatic logic [FRAME_LEN_W-1:0] sat_inc_len(input logic [FRAME_LEN_W-1:0] v);
    logic [FRAME_LEN_W-1:0] r;
    r = (v == {FRAME_LEN_W{1'b1}}) ? v : v + FRAME_LEN_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/rx_word_buffer_fifo.sv
// rx_sync_fifo: first-word-fall-through synchronous FIFO.
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   push, wr_data     write request (unqualified) and data
//   pop               read request (unqualified); ignored while empty
//   push_ok           push was accepted this cycle (combinational)
//   rd_data           head entry, meaningful while empty = 0
//   empty, full       registered status flags
//   level             number of stored entries, 0..DEPTH
module rx_sync_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int ADDR_W     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output logic                  push_ok,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_W:0]       level
);

  localparam logic [ADDR_W:0] LVL_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LVL_ONE  = (ADDR_W+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]       level_q, level_d;
  logic                  empty_q, full_q;
  logic                  pop_ok;

  // A pop on a full FIFO frees the slot the simultaneous push writes into.
  assign pop_ok  = pop & ~empty_q;
  assign push_ok = push & (~full_q | pop_ok);

  always_comb begin
    level_d = level_q;
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
      level_q <= level_d;
      empty_q <= (level_d == '0);
      full_q  <= (level_d == LVL_FULL);
    end
  end

  // Storage carries no reset; the head is read asynchronously so a pushed
  // word falls through to rd_data in the cycle after it is written.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign empty   = empty_q;
  assign full    = full_q;
  assign level   = level_q;

endmodule

// File: rtl/rx_word_buffer.sv
// rx_word_buffer: buffers deserializer words and tracks frame boundaries.
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   wr_valid, wr_data     deserializer word strobe (rising edge) and data
//   frame_end             deserializer rx interrupt (rising edge = end of frame)
//   rd_en                 pop request; rd_data shows the FIFO head
//   empty, full, level    FIFO status
//   overflow, clear_ovf   sticky word-dropped flag and its clear
//   frame_len             words accepted in the last completed frame
//   en_irq, clear_irq     frame interrupt enable and clear
//   frame_irq             sticky frame-done interrupt
//   busy                  a frame is being received
module rx_word_buffer
  import phy_wifi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = RX_BUF_DEPTH,
  parameter int ADDR_W     = RX_BUF_ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  input  logic                   frame_end,
  input  logic                   rd_en,
  output logic [DATA_WIDTH-1:0]  rd_data,
  output logic                   empty,
  output logic                   full,
  output logic [ADDR_W:0]        level,
  output logic                   overflow,
  input  logic                   clear_ovf,
  output logic [FRAME_LEN_W-1:0] frame_len,
  input  logic                   en_irq,
  input  logic                   clear_irq,
  output logic                   frame_irq,
  output logic                   busy
);

  logic                   wr_valid_d_q, frame_end_d_q;
  logic                   push, fe, push_ok, push_drop;
  logic                   overflow_q, frame_irq_q;
  logic [FRAME_LEN_W-1:0] word_cnt_q, frame_len_q;
  rx_state_e              state_q;

  // Level inputs from the deserializer count once per rising edge.
  assign push      = wr_valid & ~wr_valid_d_q;
  assign fe        = frame_end & ~frame_end_d_q;
  assign push_drop = push & ~push_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_valid_d_q  <= 1'b0;
      frame_end_d_q <= 1'b0;
    end else begin
      wr_valid_d_q  <= wr_valid;
      frame_end_d_q <= frame_end;
    end
  end

  rx_sync_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (wr_data),
    .pop     (rd_en),
    .push_ok (push_ok),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .level   (level)
  );

  // Set has priority over a coincident clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (push_drop) begin
      overflow_q <= 1'b1;
    end else if (clear_ovf) begin
      overflow_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      word_cnt_q  <= '0;
      frame_len_q <= '0;
      frame_irq_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fe) begin
            // Frame end with no words received: report an empty frame.
            frame_len_q <= '0;
            word_cnt_q  <= '0;
          end else if (push_ok) begin
            word_cnt_q <= sat_inc_len(word_cnt_q);
            state_q    <= RECV;
          end
        end
        RECV: begin
          if (fe) begin
            // A word accepted on the closing cycle still belongs to this frame.
            frame_len_q <= push_ok ? sat_inc_len(word_cnt_q) : word_cnt_q;
            word_cnt_q  <= '0;
            state_q     <= IDLE;
          end else if (push_ok) begin
            word_cnt_q <= sat_inc_len(word_cnt_q);
          end
        end
        default: state_q <= IDLE;
      endcase

      if (fe && en_irq) begin
        frame_irq_q <= 1'b1;
      end else if (clear_irq) begin
        frame_irq_q <= 1'b0;
      end
    end
  end

  assign overflow  = overflow_q;
  assign frame_len = frame_len_q;
  assign frame_irq = frame_irq_q;
  assign busy      = (state_q == RECV);

endmodule
